// File: rtl/tri_assembler_pkg.sv
// vtx_pkg: shared constants, FSM/primitive enums and the triangle-count helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vtx_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } asm_state_t;

  typedef enum logic {
    PRIM_LIST  = 1'b0,
    PRIM_STRIP = 1'b1
  } prim_mode_t;

  // Triangles a batch of n vertices produces; fewer than 3 vertices make none.
  function automatic logic [ADDR_W:0] tri_owed(input prim_mode_t m, input logic [ADDR_W:0] n);
    logic [ADDR_W:0] r;
    if (n < (ADDR_W+1)'(3)) begin
      r = '0;
    end else if (m == PRIM_STRIP) begin
      r = n - (ADDR_W+1)'(2);
    end else begin
      r = n / (ADDR_W+1)'(3);
    end
    return r;
  endfunction

endpackage

// File: rtl/tri_assembler_if.sv
// tri_assembler_if: vertex-buffer read port plus the triangle valid/ready stream.
// Latency: n/a (wires only); buf_rdata is combinational from buf_addr.
// Backpressure: tri_ready from the consumer stalls the assembler.
interface tri_assembler_if;
  import vtx_pkg::*;

  logic                  buf_en;
  logic                  buf_write;
  logic [ADDR_W-1:0]     buf_addr;
  logic [DATA_W-1:0]     buf_rdata;
  logic                  tri_valid;
  logic                  tri_ready;
  logic [3*DATA_W-1:0]   tri_data;

  modport master (
    output buf_en, buf_write, buf_addr, tri_valid, tri_data,
    input  buf_rdata, tri_ready
  );

  modport slave (
    input  buf_en, buf_write, buf_addr, tri_valid, tri_data,
    output buf_rdata, tri_ready
  );

endinterface

// File: rtl/tri_assembler_window.sv
// tri_window: 3-vertex shift window, strip winding swap, optional degenerate compare (TRI_DEGEN_CULL_EN).
// Latency: one vertex captured per shift_en cycle; tri_data is combinational from the window.
// Backpressure: window only moves on shift_en, so tri_data is frozen while the consumer stalls.
module tri_window
  import vtx_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                swap,
`ifdef TRI_DEGEN_CULL_EN
  output logic                degen,
`endif
  output logic [3*DATA_W-1:0] tri_data
);

  logic [DATA_W-1:0] w0, w1, w2;

  // Oldest vertex falls out of w0, the freshly read word enters at w2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (shift_en) begin
      w0 <= w1;
      w1 <= w2;
      w2 <= rdata;
    end
  end

  // Odd strip triangles swap the two older vertices to keep a consistent winding.
  assign tri_data = swap ? {w2, w0, w1} : {w2, w1, w0};

`ifdef TRI_DEGEN_CULL_EN
  // Looks at the window as it will be after this capture: {rdata, w2, w1}.
  assign degen = (w1 == w2) || (w1 == rdata) || (w2 == rdata);
`endif

endmodule

// File: rtl/tri_assembler.sv
// tri_assembler: walks the vertex buffer and streams list/strip triangles; TRI_DEGEN_CULL_EN drops degenerates.
// Latency: first tri_valid 4 cycles after start; next one 2 (strip) or 4 (list) cycles after a handshake.
// Backpressure: holds tri_data and stops reading the buffer while tri_valid is high and tri_ready is low.
module tri_assembler
  import vtx_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [ADDR_W:0] vtx_count,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] tri_count,
  tri_assembler_if.master bus
);

  asm_state_t        state, state_nxt;
  prim_mode_t        mode_q;
  logic [ADDR_W:0]   owed_q;
  logic [ADDR_W:0]   tri_idx;
  logic [ADDR_W:0]   cnt_clamp;
  logic [ADDR_W:0]   owed_new;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        fetch_left;
  logic              shift_en;
  logic              advance;
  logic              last_tri;
  logic              swap;
  logic              drop_tri;

  assign cnt_clamp = (vtx_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : vtx_count;
  assign owed_new  = tri_owed(prim_mode_t'(mode), cnt_clamp);
  assign last_tri  = ((tri_idx + 1'b1) == owed_q);
  assign swap      = (mode_q == PRIM_STRIP) && tri_idx[0];
  assign busy      = (state != IDLE);
  assign bus.buf_write = 1'b0;

`ifdef TRI_DEGEN_CULL_EN
  logic degen;
  assign drop_tri = degen;
`else
  assign drop_tri = 1'b0;
`endif

  tri_window u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .rdata    (bus.buf_rdata),
    .swap     (swap),
`ifdef TRI_DEGEN_CULL_EN
    .degen    (degen),
`endif
    .tri_data (bus.tri_data)
  );

  // State register; reset aborts any batch in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the per-state buffer/stream strobes.
  always_comb begin
    state_nxt     = state;
    shift_en      = 1'b0;
    advance       = 1'b0;
    bus.buf_en    = 1'b0;
    bus.buf_addr  = '0;
    bus.tri_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (owed_new == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        bus.buf_en   = 1'b1;
        bus.buf_addr = rd_ptr;
        shift_en     = 1'b1;
        if (fetch_left == 2'd1) begin
          if (drop_tri) begin
            advance   = 1'b1;
            state_nxt = last_tri ? DONE : FETCH;
          end else begin
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        bus.tri_valid = 1'b1;
        if (bus.tri_ready) begin
          advance   = 1'b1;
          state_nxt = last_tri ? DONE : FETCH;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Batch bookkeeping: latch on start, advance pointer per fetch, count finished triangles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= PRIM_LIST;
      owed_q     <= '0;
      rd_ptr     <= '0;
      tri_idx    <= '0;
      tri_count  <= '0;
      fetch_left <= 2'd0;
      done       <= 1'b0;
    end else begin
      done <= (state == DONE);
      if ((state == IDLE) && start) begin
        mode_q     <= prim_mode_t'(mode);
        owed_q     <= owed_new;
        rd_ptr     <= '0;
        tri_idx    <= '0;
        tri_count  <= '0;
        fetch_left <= 2'd3;
      end
      if (shift_en) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fetch_left <= fetch_left - 1'b1;
      end
      // A strip reuses two vertices, so later strip triangles need only one new fetch.
      if (advance) begin
        tri_idx    <= tri_idx + 1'b1;
        fetch_left <= (mode_q == PRIM_STRIP) ? 2'd1 : 2'd3;
        if (state == EMIT) begin
          tri_count <= tri_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_assembler.sv
// tb_tri_assembler: table vectors, reset/cull corner sequences and random batches against a vertex-list model.
// Latency: checks first-valid, inter-triangle gaps and done timing.
// Backpressure: exercises tri_ready stalls and checks tri_data holds.
module tb_tri_assembler;
  import vtx_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [ADDR_W:0] vtx_count;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] tri_count;

  tri_assembler_if bus ();

  logic [DATA_W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  assign bus.buf_rdata = mem[bus.buf_addr];

  tri_assembler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .vtx_count (vtx_count),
    .busy      (busy),
    .done      (done),
    .tri_count (tri_count),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [95:0] got [$];
  logic [95:0] exp_q [$];
  int exp_fetch;
  int done_cnt, en_cycles, addr_bad, first_valid, done_cyc, gap_bad, stable_bad;

`ifdef TRI_DEGEN_CULL_EN
  localparam int EXP_CULL = 1;
`else
  localparam int EXP_CULL = 2;
`endif

  typedef struct {
    bit          m;
    int          cnt;
    int          base;
    int          stall;
    int          exp_n;
    logic [95:0] e [3];
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] tri3(input logic [31:0] v2, input logic [31:0] v1, input logic [31:0] v0);
    return {v2, v1, v0};
  endfunction

  // Reference: enumerate triangles straight from the vertex list.
  function automatic void build_model(input bit m, input int cnt);
    int n;
    logic [31:0] a, b, c;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    exp_q.delete();
    exp_fetch = 0;
    if (n >= 3) begin
      if (!m) begin
        exp_fetch = 3 * (n / 3);
        for (int t = 0; t < n / 3; t++) begin
          a = mem[3*t]; b = mem[3*t+1]; c = mem[3*t+2];
`ifdef TRI_DEGEN_CULL_EN
          if (a == b || b == c || a == c) continue;
`endif
          exp_q.push_back({c, b, a});
        end
      end else begin
        exp_fetch = n;
        for (int k = 0; k <= n - 3; k++) begin
          a = mem[k]; b = mem[k+1]; c = mem[k+2];
`ifdef TRI_DEGEN_CULL_EN
          if (a == b || b == c || a == c) continue;
`endif
          if (k % 2 == 1) exp_q.push_back({c, a, b});
          else            exp_q.push_back({c, b, a});
        end
      end
    end
  endfunction

  // stall: 0 always ready, 1 random ready, 2 ready low for the first 4 valid cycles.
  task automatic run_batch(input bit m, input int cnt, input int stall, input bit noise);
    int cyc, valid_age, last_hs;
    bit prev_valid, prev_ready, r, fin;
    logic [95:0] prev_data;
    build_model(m, cnt);
    got.delete();
    done_cnt = 0; en_cycles = 0; addr_bad = 0; first_valid = -1; done_cyc = -1;
    gap_bad = 0; stable_bad = 0;
    cyc = 0; valid_age = 0; last_hs = -1; prev_valid = 0; prev_ready = 0; fin = 0;
    prev_data = '0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    vtx_count = (ADDR_W+1)'(cnt);
    bus.tri_ready = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (noise && busy) begin
        start = ($urandom_range(0, 2) == 0);
        mode = 1'($urandom_range(0, 1));
        vtx_count = (ADDR_W+1)'($urandom_range(0, 20));
      end
      if (bus.buf_en) begin
        if (bus.buf_addr != en_cycles[ADDR_W-1:0]) addr_bad++;
        en_cycles++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.tri_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_valid && !prev_ready && bus.tri_data !== prev_data) stable_bad++;
        if (!prev_valid || prev_ready) begin
          valid_age = 0;
          if (last_hs >= 0 && (cyc - last_hs) != (m ? 2 : 4)) gap_bad++;
        end
      end
      case (stall)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (valid_age >= 4);
      endcase
      bus.tri_ready = r;
      if (bus.tri_valid && r) begin
        got.push_back(bus.tri_data);
        last_hs = cyc;
      end
      if (bus.tri_valid) valid_age++;
      prev_valid = bus.tri_valid;
      prev_ready = r;
      prev_data = bus.tri_data;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
      if (cyc > 400) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: no done within 400 cycles (mode %0d count %0d)", m, cnt);
        fin = 1;
      end
    end
    check("tri_count_out", tri_count, exp_q.size());
    check("num_tris", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("tri%0d", i), got[i], exp_q[i]);
    check("done_pulses", done_cnt, 1);
    check("fetch_cycles", en_cycles, exp_fetch);
    check("fetch_addr_seq", addr_bad, 0);
    check("data_stable", stable_bad, 0);
    check("busy_end", busy, 0);
    if (exp_fetch == 0) begin
      check("short_done_lat", done_cyc, 2);
      check("short_valid_never", first_valid, -1);
    end
`ifndef TRI_DEGEN_CULL_EN
    if (exp_fetch > 0) check("first_valid_lat", first_valid, 4);
    check("hs_gap", gap_bad, 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    vtx_count = '0;
    bus.tri_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    vecs[0] = '{1'b0, 7,  'h10, 0, 2,  '{tri3('h12,'h11,'h10), tri3('h15,'h14,'h13), '0}};
    vecs[1] = '{1'b1, 5,  'h20, 1, 3,  '{tri3('h22,'h21,'h20), tri3('h23,'h21,'h22), tri3('h24,'h23,'h22)}};
    vecs[2] = '{1'b0, 3,  'h30, 2, 1,  '{tri3('h32,'h31,'h30), '0, '0}};
    vecs[3] = '{1'b1, 3,  'h40, 0, 1,  '{tri3('h42,'h41,'h40), '0, '0}};
    vecs[4] = '{1'b0, 2,  'h50, 0, 0,  '{'0, '0, '0}};
    vecs[5] = '{1'b1, 20, 'h60, 1, 14, '{tri3('h62,'h61,'h60), tri3('h63,'h61,'h62), tri3('h64,'h63,'h62)}};
    vecs[6] = '{1'b0, 16, 'h70, 0, 5,  '{tri3('h72,'h71,'h70), tri3('h75,'h74,'h73), tri3('h78,'h77,'h76)}};
    vecs[7] = '{1'b1, 0,  'h80, 0, 0,  '{'0, '0, '0}};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_buf_en", bus.buf_en, 0);
    check("rst_buf_addr", bus.buf_addr, 0);
    check("rst_tri_valid", bus.tri_valid, 0);
    check("rst_tri_data", bus.tri_data, 0);
    check("rst_tri_count", tri_count, 0);
    check("buf_write", bus.buf_write, 0);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(vecs[v].base + i);
      run_batch(vecs[v].m, vecs[v].cnt, vecs[v].stall, 1'b0);
      check($sformatf("tbl%0d_count", v), got.size(), vecs[v].exp_n);
      for (int i = 0; i < 3 && i < vecs[v].exp_n && i < got.size(); i++)
        check($sformatf("tbl%0d_tri%0d", v, i), got[i], vecs[v].e[i]);
    end

    // Reset while a triangle is waiting in EMIT.
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'('h90 + i);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; vtx_count = 5'd3; bus.tri_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !bus.tri_valid; i++) @(negedge clk);
    check("rstmid_reached_emit", bus.tri_valid, 1);
    reset = 1'b0;
    #1;
    check("rstmid_tri_valid", bus.tri_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_buf_en", bus.buf_en, 0);
    check("rstmid_tri_data", bus.tri_data, 0);
    @(negedge clk);
    reset = 1'b1;
    run_batch(1'b0, 6, 0, 1'b0);

    // Degenerate-vertex list.
    mem[0] = 5; mem[1] = 5; mem[2] = 7; mem[3] = 1; mem[4] = 2; mem[5] = 3;
    run_batch(1'b0, 6, 0, 1'b0);
    check("cull_count", tri_count, EXP_CULL);
    if (got.size() > 0) check("cull_last_tri", got[got.size()-1], tri3(3, 2, 1));

    // Random batches with stalls and ignored starts while busy.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = (it % 2 == 1) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom);
      run_batch(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 2), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
